// File: rtl/victim_cache_pkg.sv
// Shared types and constants for the 4-way victim cache controller.
// Optional performance counters are enabled with the VICTIM_CACHE_PERF_EN macro.
package victim_cache_pkg;

  localparam int unsigned VC_TAG_W  = 27;
  localparam int unsigned VC_LINE_W = 256;
  localparam int unsigned VC_WAYS   = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WB,
    INSERT
  } vc_state_t;

  typedef logic [1:0] vc_way_t;

  // One-hot mask of a way index
  function automatic logic [VC_WAYS-1:0] way_onehot(input vc_way_t w);
    return {{(VC_WAYS-1){1'b0}}, 1'b1} << w;
  endfunction

  // Increment that sticks at all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/victim_cache_lru_unit.sv
// True-LRU tracker for the 4 victim cache ways.
// newer[i][j] = 1 means way i was loaded more recently than way j.
// State is deliberately not reset: a row becomes fully defined the first
// time its way is loaded, and the controller fills invalid ways first.
module victim_cache_lru_unit
  import victim_cache_pkg::*;
(
  input  logic    clk,
  input  logic    load_lru,
  input  vc_way_t new_access,
  output vc_way_t lru
);

  logic [VC_WAYS-1:0] newer [VC_WAYS];

  // Mark the accessed way newer than every other way
  always_ff @(posedge clk) begin
    if (load_lru) begin
      for (int unsigned i = 0; i < VC_WAYS; i++) begin
        if (vc_way_t'(i) == new_access) begin
          newer[vc_way_t'(i)] <= ~way_onehot(new_access);
        end else begin
          newer[vc_way_t'(i)][new_access] <= 1'b0;
        end
      end
    end
  end

  // The LRU way is the one newer than no other way
  always_comb begin
    lru = '0;
    for (int unsigned i = VC_WAYS; i > 0; i--) begin
      if ((newer[vc_way_t'(i - 1)] & ~way_onehot(vc_way_t'(i - 1))) == '0) begin
        lru = vc_way_t'(i - 1);
      end
    end
  end

endmodule

// File: rtl/victim_cache_ctrl.sv
// 4-way fully associative victim cache: storage, lookup/swap, eviction
// insert and dirty writeback. Define VICTIM_CACHE_PERF_EN to add the
// perf_hits / perf_misses / perf_writebacks saturating counters.
module victim_cache_ctrl
  import victim_cache_pkg::*;
#(
  parameter int unsigned TAG_W  = VC_TAG_W,
  parameter int unsigned LINE_W = VC_LINE_W,
  parameter int unsigned WAYS   = VC_WAYS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [TAG_W-1:0]  lookup_addr,
  output logic              lookup_done,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data,
  output logic              lookup_dirty,
  input  logic              evict_valid,
  output logic              evict_ready,
  input  logic [TAG_W-1:0]  evict_addr,
  input  logic [LINE_W-1:0] evict_data,
  input  logic              evict_dirty,
  output logic              mem_write,
  output logic [TAG_W-1:0]  mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp
`ifdef VICTIM_CACHE_PERF_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses,
  output logic [31:0]       perf_writebacks
`endif
);

  if (WAYS != 4) begin : g_ways_check
    $error("victim_cache_ctrl: WAYS must be 4");
  end

  vc_state_t state;

  logic [WAYS-1:0]   valid;
  logic [WAYS-1:0]   dirty;
  logic [TAG_W-1:0]  tag  [WAYS];
  logic [LINE_W-1:0] data [WAYS];

  logic [TAG_W-1:0]  pend_tag;
  logic [LINE_W-1:0] pend_data;
  logic              pend_dirty;
  vc_way_t           tgt;
  vc_way_t           hit_way;
  logic              evict_open;

  logic              lk_hit;
  vc_way_t           lk_way;
  logic              ev_match;
  vc_way_t           ev_match_way;
  logic              free_found;
  vc_way_t           free_way;
  vc_way_t           sel_way;
  vc_way_t           lru;
  logic              load_lru;

  assign evict_ready = evict_open & ~lookup_valid;
  assign load_lru    = (state == INSERT);

  victim_cache_lru_unit u_lru (
    .clk        (clk),
    .load_lru   (load_lru),
    .new_access (tgt),
    .lru        (lru)
  );

  // Tag compare for lookups and target-way selection for evictions
  always_comb begin
    lk_hit       = 1'b0;
    lk_way       = '0;
    ev_match     = 1'b0;
    ev_match_way = '0;
    free_found   = 1'b0;
    free_way     = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[vc_way_t'(w)] && tag[vc_way_t'(w)] == lookup_addr) begin
        lk_hit = 1'b1;
        lk_way = vc_way_t'(w);
      end
      if (valid[vc_way_t'(w)] && tag[vc_way_t'(w)] == evict_addr) begin
        ev_match     = 1'b1;
        ev_match_way = vc_way_t'(w);
      end
      if (!free_found && !valid[vc_way_t'(w)]) begin
        free_found = 1'b1;
        free_way   = vc_way_t'(w);
      end
    end
    if (ev_match) begin
      sel_way = ev_match_way;
    end else if (free_found) begin
      sel_way = free_way;
    end else begin
      sel_way = lru;
    end
  end

  // Control FSM with registered outputs and valid/dirty bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      evict_open   <= 1'b0;
      lookup_done  <= 1'b0;
      lookup_hit   <= 1'b0;
      lookup_dirty <= 1'b0;
      lookup_data  <= '0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      pend_tag     <= '0;
      pend_data    <= '0;
      pend_dirty   <= 1'b0;
      tgt          <= '0;
      hit_way      <= '0;
    end else begin
      lookup_done <= 1'b0;
      lookup_hit  <= 1'b0;
      case (state)
        IDLE: begin
          evict_open <= 1'b1;
          if (lookup_valid) begin
            // Compare happens on acceptance so the result is registered by
            // the LOOKUP cycle; storage cannot change in between.
            lookup_done  <= 1'b1;
            lookup_hit   <= lk_hit;
            lookup_dirty <= lk_hit & dirty[lk_way];
            if (lk_hit) begin
              lookup_data <= data[lk_way];
            end
            hit_way    <= lk_way;
            evict_open <= 1'b0;
            state      <= LOOKUP;
          end else if (evict_valid && evict_ready) begin
            pend_tag   <= evict_addr;
            pend_data  <= evict_data;
            pend_dirty <= evict_dirty | (ev_match & dirty[sel_way]);
            tgt        <= sel_way;
            evict_open <= 1'b0;
            if (valid[sel_way] && dirty[sel_way] && !ev_match) begin
              mem_write <= 1'b1;
              mem_addr  <= tag[sel_way];
              mem_wdata <= data[sel_way];
              state     <= WB;
            end else begin
              state <= INSERT;
            end
          end
        end
        LOOKUP: begin
          if (lookup_hit) begin
            valid[hit_way] <= 1'b0;
          end
          evict_open <= 1'b1;
          state      <= IDLE;
        end
        WB: begin
          if (mem_resp) begin
            mem_write <= 1'b0;
            state     <= INSERT;
          end
        end
        INSERT: begin
          valid[tgt] <= 1'b1;
          dirty[tgt] <= pend_dirty;
          evict_open <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line storage: tag and data written when the pending line is inserted
  always_ff @(posedge clk) begin
    if (state == INSERT) begin
      tag[tgt]  <= pend_tag;
      data[tgt] <= pend_data;
    end
  end

`ifdef VICTIM_CACHE_PERF_EN
  // Saturating hit/miss/writeback counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hits       <= '0;
      perf_misses     <= '0;
      perf_writebacks <= '0;
    end else begin
      if (state == LOOKUP) begin
        if (lookup_hit) begin
          perf_hits <= sat_inc(perf_hits);
        end else begin
          perf_misses <= sat_inc(perf_misses);
        end
      end
      if (state == WB && mem_resp) begin
        perf_writebacks <= sat_inc(perf_writebacks);
      end
    end
  end
`endif

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Self-checking bench for victim_cache_ctrl: directed vector table,
// multi-cycle corner sequences and randomized traffic against a
// behavioural model of the victim cache.
module tb_victim_cache_ctrl;

  localparam int TW = 27;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lookup_valid;
  logic [TW-1:0] lookup_addr;
  logic          lookup_done;
  logic          lookup_hit;
  logic [LW-1:0] lookup_data;
  logic          lookup_dirty;
  logic          evict_valid;
  logic          evict_ready;
  logic [TW-1:0] evict_addr;
  logic [LW-1:0] evict_data;
  logic          evict_dirty;
  logic          mem_write;
  logic [TW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp;

  victim_cache_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_addr  (lookup_addr),
    .lookup_done  (lookup_done),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .lookup_dirty (lookup_dirty),
    .evict_valid  (evict_valid),
    .evict_ready  (evict_ready),
    .evict_addr   (evict_addr),
    .evict_data   (evict_data),
    .evict_dirty  (evict_dirty),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  bit            m_valid [4];
  bit            m_dirty [4];
  logic [TW-1:0] m_tag   [4];
  logic [LW-1:0] m_data  [4];
  int unsigned   m_stamp [4];
  int unsigned   m_now = 0;

  function automatic void model_reset();
    for (int w = 0; w < 4; w++) begin
      m_valid[w] = 0;
      m_dirty[w] = 0;
    end
  endfunction

  function automatic void model_lookup(input logic [TW-1:0] a, output bit hit,
                                       output bit d, output logic [LW-1:0] dt);
    hit = 0; d = 0; dt = '0;
    for (int w = 0; w < 4; w++) begin
      if (m_valid[w] && m_tag[w] == a) begin
        hit = 1; d = m_dirty[w]; dt = m_data[w];
        m_valid[w] = 0;
      end
    end
  endfunction

  function automatic void model_evict(input logic [TW-1:0] a, input logic [LW-1:0] dt,
                                      input bit d, output bit wb,
                                      output logic [TW-1:0] wa, output logic [LW-1:0] wd);
    int t = -1;
    bit match = 0;
    for (int w = 0; w < 4; w++)
      if (m_valid[w] && m_tag[w] == a) begin t = w; match = 1; end
    if (t < 0)
      for (int w = 3; w >= 0; w--)
        if (!m_valid[w]) t = w;
    if (t < 0) begin
      t = 0;
      for (int w = 1; w < 4; w++)
        if (m_stamp[w] < m_stamp[t]) t = w;
    end
    wb = !match && m_valid[t] && m_dirty[t];
    wa = m_tag[t];
    wd = m_data[t];
    m_dirty[t] = d | (match & m_dirty[t]);
    m_valid[t] = 1;
    m_tag[t]   = a;
    m_data[t]  = dt;
    m_now++;
    m_stamp[t] = m_now;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic void check(input string name, input logic [LW-1:0] got,
                                input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endfunction

  // ---------------- transaction tasks ----------------
  task automatic finish_evict(input bit exp_wb, input logic [TW-1:0] wa,
                              input logic [LW-1:0] wd, input int unsigned delay);
    if (exp_wb) begin
      check("wb_req", mem_write, 1);
      check("wb_addr", mem_addr, wa);
      check("wb_data", mem_wdata, wd);
      repeat (delay) begin
        @(posedge clk); #1;
        check("wb_hold", mem_write, 1);
        check("wb_addr_hold", mem_addr, wa);
        check("wb_data_hold", mem_wdata, wd);
      end
      mem_resp = 1;
      @(posedge clk); #1;
      mem_resp = 0;
      check("wb_release", mem_write, 0);
    end else begin
      check("no_wb", mem_write, 0);
    end
    check("insert_ready_low", evict_ready, 0);
    @(posedge clk); #1;
    check("ready_back", evict_ready, 1);
  endtask

  task automatic do_evict(input logic [TW-1:0] a, input bit d, input int unsigned delay,
                          input bit use_tbl, input bit t_wb, input logic [TW-1:0] t_wa);
    logic [LW-1:0] dt = rand_line();
    bit m_wb;
    logic [TW-1:0] m_wa;
    logic [LW-1:0] m_wd;
    model_evict(a, dt, d, m_wb, m_wa, m_wd);
    check("ev_ready", evict_ready, 1);
    evict_valid = 1; evict_addr = a; evict_data = dt; evict_dirty = d;
    @(posedge clk); #1;
    evict_valid = 0;
    check("ev_ready_drop", evict_ready, 0);
    finish_evict(use_tbl ? t_wb : m_wb, use_tbl ? t_wa : m_wa, m_wd, delay);
  endtask

  task automatic do_lookup(input logic [TW-1:0] a, input bit use_tbl,
                           input bit t_hit, input bit t_dirty);
    bit h, d;
    logic [LW-1:0] dt;
    model_lookup(a, h, d, dt);
    if (use_tbl) begin h = t_hit; d = t_dirty; end
    lookup_valid = 1; lookup_addr = a;
    @(posedge clk); #1;
    check("lk_done", lookup_done, 1);
    check("lk_hit", lookup_hit, h);
    if (h) begin
      check("lk_dirty", lookup_dirty, d);
      check("lk_data", lookup_data, dt);
    end
    lookup_valid = 0;
    @(posedge clk); #1;
    check("lk_done_pulse", lookup_done, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            lk;
    logic [TW-1:0] addr;
    bit            dirty;
    int unsigned   delay;
    bit            exp_hit;
    bit            exp_dirty;
    bit            exp_wb;
    logic [TW-1:0] exp_waddr;
  } vec_t;

  vec_t tbl [14];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    bit h, d, wb;
    logic [LW-1:0] dt, wd;
    logic [TW-1:0] wa;

    //          lk  addr       dty dly hit hd  wb  waddr
    tbl[0]  = '{0, 27'h100, 0, 0, 0, 0, 0, '0};
    tbl[1]  = '{0, 27'h101, 1, 0, 0, 0, 0, '0};
    tbl[2]  = '{0, 27'h102, 1, 0, 0, 0, 0, '0};
    tbl[3]  = '{0, 27'h103, 0, 0, 0, 0, 0, '0};
    tbl[4]  = '{0, 27'h200, 0, 0, 0, 0, 0, '0};      // B replaces clean LRU way 0
    tbl[5]  = '{1, 27'h100, 0, 0, 0, 0, 0, '0};      // A0 gone
    tbl[6]  = '{1, 27'h200, 0, 0, 1, 0, 0, '0};      // B hits
    tbl[7]  = '{0, 27'h200, 0, 0, 0, 0, 0, '0};      // B back into freed way 0
    tbl[8]  = '{0, 27'h300, 0, 3, 0, 0, 1, 27'h101}; // C evicts dirty A1
    tbl[9]  = '{0, 27'h102, 0, 0, 0, 0, 0, '0};      // tag match: no wb, dirty kept
    tbl[10] = '{1, 27'h102, 0, 0, 1, 1, 0, '0};      // A2 hit, dirty ORed
    tbl[11] = '{0, 27'h400, 0, 0, 0, 0, 0, '0};      // D into invalid way 2
    tbl[12] = '{1, 27'h103, 0, 0, 1, 0, 0, '0};      // A3 (LRU) survived
    tbl[13] = '{1, 27'h400, 0, 0, 1, 0, 0, '0};      // D hits right after insert

    rst_n = 0; lookup_valid = 0; lookup_addr = '0; evict_valid = 0;
    evict_addr = '0; evict_data = '0; evict_dirty = 0; mem_resp = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_lookup_done", lookup_done, 0);
    check("rst_lookup_hit", lookup_hit, 0);
    check("rst_lookup_dirty", lookup_dirty, 0);
    check("rst_lookup_data", lookup_data, 0);
    check("rst_evict_ready", evict_ready, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].lk) do_lookup(tbl[i].addr, 1, tbl[i].exp_hit, tbl[i].exp_dirty);
      else do_evict(tbl[i].addr, tbl[i].dirty, tbl[i].delay, 1, tbl[i].exp_wb, tbl[i].exp_waddr);
    end

    // Lookup and eviction together: lookup first, eviction waits in IDLE
    begin
      logic [LW-1:0] edata = rand_line();
      model_lookup(27'h300, h, d, dt);
      model_evict(27'h600, edata, 1, wb, wa, wd);
      lookup_valid = 1; lookup_addr = 27'h300;
      evict_valid = 1; evict_addr = 27'h600; evict_data = edata; evict_dirty = 1;
      @(posedge clk); #1;
      check("both_lk_done", lookup_done, 1);
      check("both_lk_hit", lookup_hit, h);
      check("both_lk_data", lookup_data, dt);
      check("both_ready_low", evict_ready, 0);
      lookup_valid = 0;
      @(posedge clk); #1;
      check("both_ready_idle", evict_ready, 1);
      @(posedge clk); #1;
      evict_valid = 0;
      check("both_ev_taken", evict_ready, 0);
      finish_evict(wb, wa, wd, 0);
      do_lookup(27'h600, 0, 0, 0);
    end

    // Randomized traffic over a small address pool
    for (int n = 0; n < 200; n++) begin
      logic [TW-1:0] a = 27'h500 + TW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 4) do_lookup(a, 0, 0, 0);
      else do_evict(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0, '0);
    end

    // Reset during writeback: fill with dirty lines, force a writeback, reset
    for (int i = 0; i < 4; i++) do_evict(27'h700 + TW'(i), 1, 0, 0, 0, '0);
    begin
      logic [LW-1:0] gdata = rand_line();
      model_evict(27'h7ff, gdata, 1, wb, wa, wd);
      evict_valid = 1; evict_addr = 27'h7ff; evict_data = gdata; evict_dirty = 1;
      @(posedge clk); #1;
      evict_valid = 0;
      check("rwb_req", mem_write, wb);
      check("rwb_addr", mem_addr, wa);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      check("rwb_mem_write", mem_write, 0);
      check("rwb_ready", evict_ready, 0);
      #2;
      rst_n = 1;
      model_reset();
      @(posedge clk); #1;
      check("rwb_ready_back", evict_ready, 1);
      for (int i = 0; i < 4; i++) do_lookup(27'h700 + TW'(i), 1, 0, 0);
      do_lookup(27'h7ff, 1, 0, 0);
      do_evict(27'h123, 0, 0, 1, 0, '0);
      do_lookup(27'h123, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
